// File: rtl/useq.sv
// useq: 65C02-family microcode sequencer with return stack, NMI/IRQ
// entry, forced reset-vector fetch and a sticky sequencing-fault flag.
// Ports: clk, reset (async, high), rdy stall, DB opcode, page, I mask,
// nmi (edge), irq[NIRQ] (level, 0 = highest), seq/nxt/fin/we_nxt from
// the control word; addr/sync/int_take combinational, WE and err
// registered.
module useq #(
  parameter int              AW         = 9,
  parameter int              OPW        = 8,
  parameter int              FW         = 5,
  parameter logic [AW-FW-3:0] FIN_PREFIX = 2'b10,
  parameter int              DEPTH      = 2,
  parameter int              NIRQ       = 1,
  parameter logic [AW-1:0]   VEC_RST    = 9'h1E1,
  parameter logic [AW-1:0]   VEC_NMI    = 9'h1E0,
  parameter logic [AW-1:0]   VEC_IRQ    = 9'h160
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rdy,
  input  logic [OPW-1:0]  DB,
  input  logic            page,
  input  logic            I,
  input  logic            nmi,
  input  logic [NIRQ-1:0] irq,
  input  logic [2:0]      seq,
  input  logic [AW-3:0]   nxt,
  input  logic [FW-1:0]   fin,
  input  logic            we_nxt,
  output logic [AW-1:0]   addr,
  output logic            sync,
  output logic            WE,
  output logic            int_take,
  output logic            err
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  localparam logic [2:0] SEQ_NEXT   = 3'b001;
  localparam logic [2:0] SEQ_FINISH = 3'b010;
  localparam logic [2:0] SEQ_SAVE   = 3'b011;
  localparam logic [2:0] SEQ_CALL   = 3'b100;
  localparam logic [2:0] SEQ_RET    = 3'b101;

  logic            first_q, first_d;
  logic [FW-1:0]   finish_q, finish_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic [AW-1:0]   stk_q [DEPTH];
  logic [AW-1:0]   stk_d [DEPTH];
  logic            pend_q, pend_d;
  logic            nmi_dly_q, nmi_dly_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [AW-1:0]   prev_q, prev_d;

  logic            irq_hit;
  logic [IW-1:0]   irq_idx;
  logic            stk_empty;
  logic            stk_full;
  logic            is_jmp;
  logic            is_fin;
  logic            is_ret;
  logic            op_ok;
  logic            nmi_edge;
  logic            bad_op;

  always_comb begin
    irq_hit = 1'b0;
    irq_idx = '0;
    // Scan downwards so the lowest asserted index wins.
    for (int k = NIRQ - 1; k >= 0; k--) begin
      if (irq[k]) begin
        irq_hit = 1'b1;
        irq_idx = IW'(k);
      end
    end
    stk_empty = (sp_q == '0);
    stk_full  = (sp_q == SPW'(DEPTH));
    is_jmp = !first_q && (seq == SEQ_NEXT ||
                          seq == SEQ_SAVE ||
                          seq == SEQ_CALL);
    is_fin = !first_q && (seq == SEQ_FINISH);
    // RET on an empty stack falls through to the fetch path.
    is_ret = !first_q && (seq == SEQ_RET) && !stk_empty;
    addr     = {1'b0, DB};
    sync     = 1'b0;
    int_take = 1'b0;
    unique case (1'b1)
      first_q: addr = VEC_RST;
      is_jmp:  addr = {1'b1, page, nxt};
      is_fin:  addr = {1'b1, page, FIN_PREFIX, finish_q};
      is_ret:  addr = stk_q[0];
      default: begin
        sync = 1'b1;
        if (rdy && pend_q) begin
          addr     = VEC_NMI;
          int_take = 1'b1;
        end else if (rdy && !I && irq_hit) begin
          addr     = VEC_IRQ + AW'(irq_idx);
          int_take = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    op_ok    = rdy && !first_q;
    nmi_edge = nmi && !nmi_dly_q;
    bad_op   = (seq[2:1] == 2'b11) ||
               (seq == SEQ_RET && stk_empty) ||
               (seq == SEQ_CALL && stk_full);
    first_d   = first_q && !rdy;
    nmi_dly_d = nmi;
    we_d      = rdy ? we_nxt : we_q;
    prev_d    = rdy ? addr : prev_q;
    err_d     = err_q || (op_ok && bad_op);
    finish_d  = (op_ok && seq == SEQ_SAVE) ? fin : finish_q;
    // A new edge beats the clear at an instruction boundary.
    pend_d    = nmi_edge || (pend_q && !(sync && rdy));
    stk_d     = stk_q;
    sp_d      = sp_q;
    if (op_ok) begin
      if (seq == SEQ_CALL) begin
        // Shift down; when full the oldest frame drops off the end.
        for (int i = DEPTH - 1; i > 0; i--) begin
          stk_d[i] = stk_q[i-1];
        end
        stk_d[0] = prev_q + AW'(1);
        if (!stk_full) begin
          sp_d = sp_q + SPW'(1);
        end
      end else if (is_ret) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          stk_d[i] = stk_q[i+1];
        end
        sp_d = sp_q - SPW'(1);
      end
      if (sync) begin
        sp_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_q   <= 1'b1;
      finish_q  <= '0;
      sp_q      <= '0;
      stk_q     <= '{default: '0};
      pend_q    <= 1'b0;
      nmi_dly_q <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      prev_q    <= VEC_RST;
    end else begin
      first_q   <= first_d;
      finish_q  <= finish_d;
      sp_q      <= sp_d;
      stk_q     <= stk_d;
      pend_q    <= pend_d;
      nmi_dly_q <= nmi_dly_d;
      we_q      <= we_d;
      err_q     <= err_d;
      prev_q    <= prev_d;
    end
  end

  assign WE  = we_q;
  assign err = err_q;

endmodule
